clkgen_multi_060: RTL

Parametrised, multi-channel programmable clock/tick generator; successor to the fixed single-output divider in the car-control path. Each channel derives a square-wave enable clock and a one-cycle tick from the system clock, with runtime-programmable period and high time. Configuration updates are shadowed and applied only at period boundaries, so the outputs never glitch. A global sync strobe phase-aligns all channels. It feeds the PWM, sensor-poll and servo timing blocks.

---
 rtl/clkgen_pkg_060.sv | 25 ++
 rtl/clkgen_ch_060.sv | 118 +++++++++++
 rtl/clkgen_multi_060.sv | 62 ++++++
 3 files changed

// File: rtl/clkgen_pkg_060.sv
// Shared definitions for the multi-channel clock/tick generator.
//   W_DEF        : default (and maximum) counter/divisor/high-time width
//   INCLK_DEF    : nominal input clock in Hz, used only to derive reset defaults
//   DIV_RST_DEF  : default per-channel divisor loaded at reset
//   HIGH_RST_DEF : default per-channel high time loaded at reset
//   ch_cfg_t     : one channel's {div, high} configuration pair
//   high_eff()   : high time clamped to the period
package clkgen_pkg_060;

    localparam int unsigned W_DEF        = 32;
    localparam int unsigned INCLK_DEF    = 100_000_000;
    localparam int unsigned DIV_RST_DEF  = INCLK_DEF / 500;
    localparam int unsigned HIGH_RST_DEF = DIV_RST_DEF >> 1;

    typedef struct packed {
        logic [W_DEF-1:0] div;
        logic [W_DEF-1:0] high;
    } ch_cfg_t;

    function automatic logic [W_DEF-1:0] high_eff(input logic [W_DEF-1:0] div,
                                                  input logic [W_DEF-1:0] high);
        return (high < div) ? high : div;
    endfunction

endpackage

// File: rtl/clkgen_ch_060.sv
// One channel of the clock/tick generator: period counter, shadow config and apply logic.
// Ports:
//   i_clk, i_rst_n : system clock, asynchronous active-low reset
//   i_we           : write strobe for this channel's shadow config (already decoded)
//   i_div, i_high  : config bus (period and high time in cycles)
//   i_sync         : restart at cycle 0 and apply any pending config
//   o_clk          : registered square wave, high for min(high, div) cycles per period
//   o_tick         : registered one-cycle pulse on the first cycle of each period
//   o_pend         : shadow written but not yet applied
// Config is stored at W_DEF width (W must not exceed W_DEF); upper bits stay zero when W < W_DEF.
module clkgen_ch_060
    import clkgen_pkg_060::*;
#(
    parameter int unsigned W        = W_DEF,
    parameter int unsigned DIV_RST  = DIV_RST_DEF,
    parameter int unsigned HIGH_RST = HIGH_RST_DEF
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_we,
    input  logic [W-1:0] i_div,
    input  logic [W-1:0] i_high,
    input  logic         i_sync,
    output logic         o_clk,
    output logic         o_tick,
    output logic         o_pend
);

    localparam ch_cfg_t CfgRst = '{div: W_DEF'(DIV_RST), high: W_DEF'(HIGH_RST)};

    ch_cfg_t      r_act;
    ch_cfg_t      r_shd;
    logic [W-1:0] r_cnt;
    logic         r_pend;
    logic         r_started;
    logic         r_clk;
    logic         r_tick;

    ch_cfg_t      w_bus;
    ch_cfg_t      w_act_d;
    ch_cfg_t      w_shd_d;
    logic [W-1:0] w_cnt_d;
    logic         w_pend_d;
    logic         w_started_d;
    logic         w_en_cur;
    logic         w_en_d;
    logic         w_wrap;
    logic         w_apply;
    logic         w_clk_d;
    logic         w_tick_d;

    assign w_bus    = '{div: W_DEF'(i_div), high: W_DEF'(i_high)};
    assign w_en_cur = (r_act.div >= W_DEF'(2));
    assign w_wrap   = (W_DEF'(r_cnt) == (r_act.div - W_DEF'(1)));

    always_comb begin
        w_act_d     = r_act;
        w_shd_d     = r_shd;
        w_pend_d    = r_pend;
        w_cnt_d     = r_cnt;
        w_started_d = r_started;

        // Apply point: next count would be 0. A not-yet-started channel (after reset or
        // after leaving DISABLED) also counts, so its first tick lands on the next cycle.
        w_apply = !w_en_cur || !r_started || i_sync || w_wrap;

        if (w_apply) begin
            w_cnt_d = '0;
            if (i_we) begin
                // Write coinciding with the apply point goes straight to the active set.
                w_act_d  = w_bus;
                w_shd_d  = w_bus;
                w_pend_d = 1'b0;
            end else if (r_pend) begin
                w_act_d  = r_shd;
                w_pend_d = 1'b0;
            end
            // Coming out of DISABLED spends one cycle loaded-but-idle before the first tick.
            w_started_d = w_en_cur;
        end else begin
            w_cnt_d = r_cnt + W'(1);
            if (i_we) begin
                w_shd_d  = w_bus;
                w_pend_d = 1'b1;
            end
        end

        // Outputs come from next-state values so they line up with the count they describe.
        w_en_d   = w_started_d && (w_act_d.div >= W_DEF'(2));
        w_tick_d = w_en_d && (w_cnt_d == '0);
        w_clk_d  = w_en_d && (W_DEF'(w_cnt_d) < high_eff(w_act_d.div, w_act_d.high));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_act     <= CfgRst;
            r_shd     <= CfgRst;
            r_cnt     <= '0;
            r_pend    <= 1'b0;
            r_started <= 1'b0;
            r_clk     <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_act     <= w_act_d;
            r_shd     <= w_shd_d;
            r_cnt     <= w_cnt_d;
            r_pend    <= w_pend_d;
            r_started <= w_started_d;
            r_clk     <= w_clk_d;
            r_tick    <= w_tick_d;
        end
    end

    assign o_clk  = r_clk;
    assign o_tick = r_tick;
    assign o_pend = r_pend;

endmodule

// File: rtl/clkgen_multi_060.sv
// Multi-channel programmable clock/tick generator top level.
// Decodes the config write to one channel and fans the sync strobe out to all channels.
// Ports:
//   inclk_060, rst_n_060        : system clock, asynchronous active-low reset
//   cfg_we_060, cfg_ch_060      : config write strobe and target channel (>= CH ignored)
//   cfg_div_060, cfg_high_060   : new period and high time in cycles
//   sync_060                    : restart all channels at cycle 0
//   clk_o_060, tick_o_060       : per-channel square wave and period-start pulse
//   pend_o_060                  : per-channel shadow-pending flag
module clkgen_multi_060
    import clkgen_pkg_060::*;
#(
    parameter int unsigned CH        = 4,
    parameter int unsigned W         = W_DEF,
    parameter int unsigned INCLK_060 = INCLK_DEF,
    parameter int unsigned DIV_RST   = INCLK_060 / 500,
    parameter int unsigned HIGH_RST  = DIV_RST >> 1,
    localparam int unsigned CHW      = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic           inclk_060,
    input  logic           rst_n_060,
    input  logic           cfg_we_060,
    input  logic [CHW-1:0] cfg_ch_060,
    input  logic [W-1:0]   cfg_div_060,
    input  logic [W-1:0]   cfg_high_060,
    input  logic           sync_060,
    output logic [CH-1:0]  clk_o_060,
    output logic [CH-1:0]  tick_o_060,
    output logic [CH-1:0]  pend_o_060
);

    logic          w_cfg_ok;
    logic [CH-1:0] w_we;

    // When CH fills the select field every code is a real channel.
    if (CH == (2 ** CHW)) begin : g_ok_full
        assign w_cfg_ok = 1'b1;
    end else begin : g_ok_range
        assign w_cfg_ok = (32'(cfg_ch_060) < CH);
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        assign w_we[c] = cfg_we_060 && w_cfg_ok && (cfg_ch_060 == CHW'(c));

        clkgen_ch_060 #(
            .W        (W),
            .DIV_RST  (DIV_RST),
            .HIGH_RST (HIGH_RST)
        ) u_ch (
            .i_clk   (inclk_060),
            .i_rst_n (rst_n_060),
            .i_we    (w_we[c]),
            .i_div   (cfg_div_060),
            .i_high  (cfg_high_060),
            .i_sync  (sync_060),
            .o_clk   (clk_o_060[c]),
            .o_tick  (tick_o_060[c]),
            .o_pend  (pend_o_060[c])
        );
    end

endmodule
